// File: rtl/input_pingpong_buffer.sv
// Ping-pong input row buffer: loader fills one bank while the array
// streams rows from the other through a two-entry output stage.
module input_pingpong_buffer #(
    parameter  int ARRAY_SIZE = 64,
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 64,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int ROW_W      = ARRAY_SIZE * DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ROW_W-1:0] wr_data,
    input  logic             wr_last,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [ROW_W-1:0] rd_data,
    output logic             rd_last,
    output logic             wr_bank,
    output logic             rd_bank,
    output logic [1:0]       bank_full
);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    localparam logic [ADDR_WIDTH-1:0] A_ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   C_ONE     = (ADDR_WIDTH + 1)'(1);

    state_t state, state_nx;

    logic                  init_done;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   count [2];
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    (* ram_style = "block" *) logic [ROW_W-1:0] mem0 [DEPTH];
    (* ram_style = "block" *) logic [ROW_W-1:0] mem1 [DEPTH];

    logic [ROW_W-1:0] q0, q1, q_data, s_data;
    logic             q_valid, q_last, s_valid, s_last;

    logic       wr_acc, wr_close;
    logic       rd_issue, rd_pop, rd_done, more, issue_last;
    logic [1:0] full_set, full_clr;

    assign wr_ready = init_done & ~bank_full[wr_bank];
    assign wr_acc   = wr_valid & wr_ready;
    assign wr_close = wr_acc & (wr_last | (wr_ptr == LAST_ADDR));

    assign rd_addr    = rd_ptr[ADDR_WIDTH-1:0];
    assign more       = rd_ptr < count[rd_bank];
    assign issue_last = rd_ptr == (count[rd_bank] - C_ONE);

    // Skid entry, when occupied, always holds the older row.
    assign q_data   = rd_bank ? q1 : q0;
    assign rd_valid = s_valid | q_valid;
    assign rd_last  = s_valid ? s_last : (q_valid & q_last);
    assign rd_data  = s_valid ? s_data : (q_valid ? q_data : '0);
    assign rd_pop   = rd_valid & rd_ready;
    assign rd_done  = rd_pop & rd_last;

    assign full_set = wr_close ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign full_clr = rd_done  ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (wr_acc && !wr_bank) mem0[wr_ptr] <= wr_data;
        if (rd_issue && !rd_bank) q0 <= mem0[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_acc && wr_bank) mem1[wr_ptr] <= wr_data;
        if (rd_issue && rd_bank) q1 <= mem1[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done <= 1'b0;
            wr_ptr    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
            count[0]  <= '0;
            count[1]  <= '0;
            rd_ptr    <= '0;
        end else begin
            init_done <= 1'b1;
            if (wr_acc) wr_ptr <= wr_close ? '0 : wr_ptr + A_ONE;
            if (wr_close) begin
                count[wr_bank] <= {1'b0, wr_ptr} + C_ONE;
                wr_bank        <= ~wr_bank;
            end
            if (rd_done) begin
                rd_ptr  <= '0;
                rd_bank <= ~rd_bank;
            end else if (rd_issue) begin
                rd_ptr <= rd_ptr + C_ONE;
            end
            bank_full <= (bank_full | full_set) & ~full_clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_last  <= 1'b0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
            s_data  <= '0;
        end else if (rd_issue) begin
            q_valid <= 1'b1;
            q_last  <= issue_last;
            if (q_valid && !rd_pop) begin
                s_valid <= 1'b1;
                s_data  <= q_data;
                s_last  <= q_last;
            end
        end else if (rd_pop) begin
            if (s_valid) s_valid <= 1'b0;
            else         q_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bank_full[rd_bank]) state_nx = FETCH;
            FETCH:   state_nx = STREAM;
            STREAM:  if (rd_done) state_nx = bank_full[~rd_bank] ? FETCH : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Prefetch only while the skid slot is free; no rd_ready in this path.
    always_comb begin
        rd_issue = 1'b0;
        unique case (1'b1)
            state == FETCH:  rd_issue = 1'b1;
            state == STREAM: rd_issue = more & ~s_valid;
            default:         rd_issue = 1'b0;
        endcase
    end

endmodule
